fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
//  Instruction-fetch (IF) stage of the Tinker 5-stage pipeline. Owns the fetch PC and reads
//  32-bit words from the instruction port of memory (combinational, same-cycle data). Buffers
//  fetched {pc, instruction} pairs in a small FIFO that feeds the decode (ID) stage through a
//  valid/ready handshake. Accepts PC redirects from EX (jumps, branches, call, return) and
//  stops fetching once a halt word has been fetched.
// PARAMETERS
//  RESET_PC  64'h2000  fetch PC loaded on reset
//  DEPTH     4         FIFO entries; power of 2, >= 2
// PORTS
//  clk             in   1   clock, rising edge
//  reset           in   1   asynchronous, active-high reset
//  imem_addr       out  64  current fetch PC, driven to the memory instruction port
//  imem_data       in   32  instruction word at imem_addr, valid in the same cycle
//  redirect_valid  in   1   EX is taking a control transfer this cycle
//  redirect_pc     in   64  target PC; sampled when redirect_valid=1
//  id_valid        out  1   FIFO head holds a valid instruction
//  id_ready        in   1   ID consumes the head this cycle when id_valid=1
//  id_ir           out  32  head instruction word
//  id_pc           out  64  head instruction PC
//  fetch_stopped   out  1   halt word fetched; no further fetch until redirect or reset
//  occupancy       out  $clog2(DEPTH)+1  number of valid FIFO entries
// BEHAVIOUR
//  Clocking and reset:
//  - One clock: clk. Reset is asynchronous and active-high (reset).
//  - On reset: fpc=RESET_PC, FIFO empty (count=0, rd_ptr=wr_ptr=0), state=FETCH.
//  - Outputs during reset: imem_addr=RESET_PC, id_valid=0, id_ir=0, id_pc=0,
//    fetch_stopped=0, occupancy=0. All FIFO storage is cleared to 0.
//  - Reset asserted mid-operation discards all queued entries and any pending redirect.
//  Handshake and timing:
//  - deq = id_valid & id_ready.
//  - enq = (state==FETCH) & (count<DEPTH | deq) & !redirect_valid.
//  - A full FIFO accepts a new entry in the same cycle it dequeues one.
//  - On enq, entry[wr_ptr] <= {fpc, imem_data} and fpc <= fpc+4 (64-bit, wraps modulo 2^64).
//  - Pointers wrap modulo DEPTH. count <= count + enq - deq.
//  - Head outputs are first-word-fall-through: id_ir/id_pc = entry[rd_ptr]; id_valid = (count!=0).
//  - A word enqueued at edge N is visible at ID after edge N; minimum IF->ID latency is 1 cycle.
//  Halt:
//  - A word is a halt when imem_data[31:27]==5'h0f and imem_data[3:0]==4'h0.
//  - Enqueuing a halt sets state<=STOPPED and fetch_stopped<=1. fpc still advances by 4.
//  - The halt word itself is delivered to ID normally.
//  - In STOPPED, imem_addr holds and no enqueue occurs. Draining to ID continues.
//  State machine:
//  - FETCH -> STOPPED on a halt enqueue.
//  - STOPPED -> FETCH on redirect_valid.
//  - Any state -> FETCH on reset.
//  Redirect (highest priority, same edge):
//  - Flush the FIFO: count=0, rd_ptr=wr_ptr=0. Entries are not cleared.
//  - Load fpc <= {redirect_pc[63:2], 2'b00}; state <= FETCH; fetch_stopped <= 0.
//  - No enqueue that cycle; an id_ready handshake in that cycle is ignored.
//  - id_valid is 0 in the cycle after a redirect. The first target word appears one cycle later.
//  Boundaries:
//  - count never exceeds DEPTH; enq into full without deq is blocked and fpc holds.
//  - deq with count==0 is impossible because id_valid=0.
//  - A redirect and a halt fetched in the same cycle resolve as redirect: the halt is dropped.
//  - Back-to-back redirects: each one reloads fpc; only the last target is fetched.
// TESTING
//  1. Reset, then imem returns sequential non-halt words and id_ready=1 ->
//     imem_addr 0x2000,0x2004,...; id_pc=0x2000 one cycle after reset release; one entry/cycle.
//  2. id_ready=0 for 6 cycles ->
//     occupancy reaches 4 and holds; imem_addr stops at 0x2010; releasing id_ready drains in order.
//  3. FIFO full and id_ready=1 ->
//     same-cycle deq+enq keeps occupancy=4 and imem_addr advances by 4 each cycle.
//  4. redirect_valid=1, redirect_pc=0x3003 while 3 entries queued ->
//     next cycle occupancy=0, id_valid=0, imem_addr=0x3000; following entry id_pc=0x3000.
//  5. Halt word 0x78000000 at 0x2008 ->
//     fetch_stopped=1 after enqueue, imem_addr holds 0x200C, halt reaches id_ir; redirect to
//     0x2100 resumes fetch.
//  6. Assert reset asynchronously mid-cycle with a full FIFO and STOPPED state ->
//     outputs immediately return to reset values with no clock edge required.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch stage: owns the fetch PC, reads instruction memory
// combinationally and queues {pc, instruction} pairs toward decode.
// Ports:
//   clk, reset                    clock, async active-high reset
//   imem_addr / imem_data         fetch PC out, same-cycle instruction word in
//   redirect_valid / redirect_pc  control transfer from EX (flush + reload PC)
//   id_valid / id_ready           FIFO head handshake toward ID
//   id_ir / id_pc                 head instruction word and its PC
//   fetch_stopped                 a halt word was fetched; fetch paused
//   occupancy                     number of valid FIFO entries
module fetch_queue_stage #(
    parameter logic [63:0] RESET_PC = 64'h2000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [63:0]              imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_ir,
    output logic [63:0]              id_pc,
    output logic                     fetch_stopped,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        S_FETCH   = 1'b0,
        S_STOPPED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [63:0]        fpc_q, fpc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [63:0]        pc_mem_q [DEPTH];
    logic [31:0]        ir_mem_q [DEPTH];

    logic deq_c;
    logic enq_c;
    logic halt_c;
    logic unused_redirect_lsbs;

    // Low PC bits are forced to word alignment on redirect.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Handshake qualifiers; redirect suppresses enqueue and overrides dequeue.
    assign halt_c = (imem_data[31:27] == 5'h0f) && (imem_data[3:0] == 4'h0);
    assign deq_c  = (count_q != '0) && id_ready;
    assign enq_c  = (state_q == S_FETCH) && ((count_q < CNT_W'(DEPTH)) || deq_c)
                    && !redirect_valid;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = S_FETCH;
        end else if (enq_c && halt_c) begin
            state_d = S_STOPPED;
        end
    end

    // Output logic; all outputs come straight from registers.
    always_comb begin
        imem_addr     = fpc_q;
        id_valid      = (count_q != '0);
        id_ir         = ir_mem_q[rd_ptr_q];
        id_pc         = pc_mem_q[rd_ptr_q];
        fetch_stopped = (state_q == S_STOPPED);
        occupancy     = count_q;
    end

    // Datapath next-state: PC, pointers and count.
    always_comb begin
        fpc_d    = fpc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            fpc_d    = {redirect_pc[63:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq_c) begin
                fpc_d    = fpc_q + 64'd4;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (deq_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq_c) - CNT_W'(deq_c);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpc_q    <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            fpc_q    <= fpc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // FIFO storage; a flush leaves contents in place, only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i] <= '0;
                ir_mem_q[i] <= '0;
            end
        end else if (enq_c) begin
            pc_mem_q[wr_ptr_q] <= fpc_q;
            ir_mem_q[wr_ptr_q] <= imem_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus randomized traffic,
// checked against a queue-based reference model of the fetch stage.
module tb_fetch_queue_stage;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [63:0] id_pc;
    logic        fetch_stopped;
    logic [2:0]  occupancy;

    fetch_queue_stage #(
        .RESET_PC (64'h2000),
        .DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_pc          (id_pc),
        .fetch_stopped  (fetch_stopped),
        .occupancy      (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] HALT = 32'h7800_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ir;
    } ent_t;

    // Reference model state
    ent_t        m_q[$];
    logic [63:0] m_fpc;
    bit          m_stop;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit is_halt(input logic [31:0] w);
        return (w[31:27] == 5'h0f) && (w[3:0] == 4'h0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fpc  = 64'h2000;
        m_stop = 0;
    endtask

    // One clock of the fetch stage as described behaviourally.
    task automatic model_clock(input logic rdy, input logic rv, input logic [63:0] rpc,
                               input logic [31:0] w);
        bit deq;
        bit enq;
        ent_t e;
        deq = (m_q.size() != 0) && rdy;
        if (rv) begin
            m_q.delete();
            m_fpc  = {rpc[63:2], 2'b00};
            m_stop = 0;
        end else begin
            enq = !m_stop && ((m_q.size() < 4) || deq);
            if (deq) void'(m_q.pop_front());
            if (enq) begin
                e.pc = m_fpc;
                e.ir = w;
                m_q.push_back(e);
                m_fpc = m_fpc + 64'd4;
                if (is_halt(w)) m_stop = 1;
            end
        end
    endtask

    task automatic check_all();
        check_eq("imem_addr", imem_addr, m_fpc);
        check_eq("id_valid", 64'(id_valid), 64'(m_q.size() != 0));
        check_eq("occupancy", 64'(occupancy), 64'(m_q.size()));
        check_eq("fetch_stopped", 64'(fetch_stopped), 64'(m_stop));
        if (m_q.size() != 0) begin
            check_eq("id_pc", id_pc, m_q[0].pc);
            check_eq("id_ir", 64'(id_ir), 64'(m_q[0].ir));
        end
    endtask

    // Called at a negedge: drive inputs, clock once, check at the next negedge.
    task automatic step(input logic rdy, input logic rv, input logic [63:0] rpc,
                        input logic [31:0] w);
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_data      = w;
        @(posedge clk);
        model_clock(rdy, rv, rpc, w);
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_addr"}, imem_addr, 64'h2000);
        check_eq({tag, "_valid"}, 64'(id_valid), 64'd0);
        check_eq({tag, "_ir"}, 64'(id_ir), 64'd0);
        check_eq({tag, "_pc"}, id_pc, 64'd0);
        check_eq({tag, "_stop"}, 64'(fetch_stopped), 64'd0);
        check_eq({tag, "_occ"}, 64'(occupancy), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] w;
        logic [63:0] rpc;
        logic        rv;

        reset          = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_data      = NOP;
        model_reset();
        #1;
        check_reset_outputs("por");
        do_reset();

        // Sequential fetch with ID always ready
        step(1'b1, 1'b0, '0, NOP);
        check_eq("t1_first_pc", id_pc, 64'h2000);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, NOP + 32'(i << 8));
        check_eq("t1_addr", imem_addr, 64'h2018);

        // Back-pressure: fill then hold
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 32'h100 + 32'(i << 4));
        check_eq("t2_occ_full", 64'(occupancy), 64'd4);
        check_eq("t2_addr_hold", imem_addr, 64'h2010);
        // Full FIFO with ready: enqueue and dequeue in the same cycle
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 32'h200 + 32'(i << 4));
        check_eq("t3_occ", 64'(occupancy), 64'd4);
        check_eq("t3_addr", imem_addr, 64'h201C);

        // Redirect with three entries queued
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, NOP);
        step(1'b1, 1'b1, 64'h3003, HALT);
        check_eq("t4_occ", 64'(occupancy), 64'd0);
        check_eq("t4_valid", 64'(id_valid), 64'd0);
        check_eq("t4_addr", imem_addr, 64'h3000);
        step(1'b0, 1'b0, '0, NOP);
        check_eq("t4_pc", id_pc, 64'h3000);

        // Halt at 0x2008, drain, then redirect resumes fetch
        do_reset();
        step(1'b0, 1'b0, '0, NOP);
        step(1'b0, 1'b0, '0, NOP);
        step(1'b0, 1'b0, '0, HALT);
        check_eq("t5_stop", 64'(fetch_stopped), 64'd1);
        check_eq("t5_addr", imem_addr, 64'h200C);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, NOP);
        check_eq("t5_addr_hold", imem_addr, 64'h200C);
        step(1'b1, 1'b0, '0, NOP);
        step(1'b1, 1'b0, '0, NOP);
        check_eq("t5_halt_head", 64'(id_ir), 64'(HALT));
        step(1'b1, 1'b1, 64'h2100, NOP);
        check_eq("t5_resume_stop", 64'(fetch_stopped), 64'd0);
        step(1'b1, 1'b0, '0, NOP);
        check_eq("t5_resume_addr", imem_addr, 64'h2104);

        // Async reset mid-cycle with full FIFO and fetch stopped
        do_reset();
        step(1'b0, 1'b0, '0, NOP);
        step(1'b0, 1'b0, '0, NOP);
        step(1'b0, 1'b0, '0, NOP);
        step(1'b0, 1'b0, '0, HALT);
        check_eq("t6_pre_occ", 64'(occupancy), 64'd4);
        check_eq("t6_pre_stop", 64'(fetch_stopped), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_all();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) == 0) w = {5'h0f, w[26:4], 4'h0};
            rv  = ($urandom_range(0, 15) == 0);
            rpc = {32'h0, $urandom};
            if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            step($urandom_range(0, 9) < 7, rv, rpc, w);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
